// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the two-requester sram-like arbiter: requester IDs
// and the transfer-size encoding carried on the size buses.
package sram_like_arbiter_pkg;

    typedef enum logic {
        ID_INST = 1'b0,
        ID_DATA = 1'b1
    } req_id_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Occupancy counter width for a queue of the given depth (holds 0..depth).
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sram_like_arbiter_id_fifo.sv
// Response-order queue: remembers which requester issued each accepted
// transaction so in-order downstream responses can be routed back.
module arb_id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     din,
    output logic                     head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // DEPTH is a power of two, so the pointers wrap on overflow.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; only slots between rd_ptr and wr_ptr are
    // ever read, and leaving it reset-free keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Two-into-one sram-like port arbiter: data has priority, inst is protected
// by a starvation counter, the address phase is locked until accepted.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          inst_req,
    input  logic                          inst_wr,
    input  logic [1:0]                    inst_size,
    input  logic [3:0]                    inst_wstrb,
    input  logic [ADDR_W-1:0]             inst_addr,
    input  logic [DATA_W-1:0]             inst_wdata,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [DATA_W-1:0]             inst_rdata,

    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [1:0]                    data_size,
    input  logic [3:0]                    data_wstrb,
    input  logic [ADDR_W-1:0]             data_addr,
    input  logic [DATA_W-1:0]             data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [DATA_W-1:0]             data_rdata,

    output logic                          m_req,
    output logic                          m_wr,
    output logic [1:0]                    m_size,
    output logic [3:0]                    m_wstrb,
    output logic [ADDR_W-1:0]             m_addr,
    output logic [DATA_W-1:0]             m_wdata,
    input  logic                          m_addr_ok,
    input  logic                          m_data_ok,
    input  logic [DATA_W-1:0]             m_rdata,

    output logic [$clog2(OUTSTANDING):0]  outstanding
);
    localparam int              SC_W       = $clog2(STARVE_LIMIT + 1);
    localparam int              OCC_W      = occ_width(OUTSTANDING);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    req_id_t         grant;
    req_id_t         lock_id;
    req_id_t         head_id;
    logic            lock;
    logic [SC_W-1:0] starve_cnt;
    logic            granted_req;
    logic            accept;
    logic            pop;
    logic            fifo_head;
    logic            fifo_full;
    logic            fifo_empty;
    logic [OCC_W-1:0] fifo_count;

    // Once the address phase has been offered, keep the same requester
    // until the downstream accepts it, so the payload never changes mid-phase.
    always_comb begin
        if (lock)
            grant = lock_id;
        else if (data_req && !(inst_req && starve_cnt == STARVE_MAX))
            grant = ID_DATA;
        else
            grant = ID_INST;
    end

    assign granted_req = (grant == ID_DATA) ? data_req : inst_req;
    assign m_req       = granted_req & ~fifo_full & ~reset;
    assign accept      = m_req & m_addr_ok;

    assign inst_addr_ok = accept & (grant == ID_INST);
    assign data_addr_ok = accept & (grant == ID_DATA);

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        m_wr    = inst_wr;
        m_size  = inst_size;
        m_wstrb = inst_wstrb;
        m_addr  = inst_addr;
        m_wdata = inst_wdata;
        if (grant == ID_DATA) begin
            m_wr    = data_wr;
            m_size  = data_size;
            m_wstrb = data_wstrb;
            m_addr  = data_addr;
            m_wdata = data_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock    <= 1'b0;
            lock_id <= ID_INST;
        end else if (m_req && !m_addr_ok) begin
            lock    <= 1'b1;
            lock_id <= grant;
        end else if (m_addr_ok) begin
            lock    <= 1'b0;
        end
    end

    // Counts data wins while inst is waiting; at the limit inst goes next.
    always_ff @(posedge clk) begin
        if (reset || !inst_req) begin
            starve_cnt <= '0;
        end else if (accept) begin
            if (grant == ID_INST)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + SC_W'(1);
        end
    end

    // A response with nothing outstanding is stray and is dropped.
    assign pop     = m_data_ok & ~fifo_empty & ~reset;
    assign head_id = req_id_t'(fifo_head);

    arb_id_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (accept),
        .pop   (pop),
        .din   (grant == ID_DATA),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign inst_data_ok = pop & (head_id == ID_INST);
    assign data_data_ok = pop & (head_id == ID_DATA);
    assign inst_rdata   = m_rdata;
    assign data_rdata   = m_rdata;
    assign outstanding  = fifo_count;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: the bench plays both upstream
// masters and the downstream slave; a queue holds the expected response order.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [3:0]  inst_wstrb, data_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        m_req, m_wr;
    logic [1:0]  m_size;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr, m_wdata;
    logic        m_addr_ok, m_data_ok;
    logic [31:0] m_rdata;
    logic [2:0]  outstanding;

    typedef struct {
        req_id_t     id;
        logic [31:0] rdata;
        logic        chk_rdata;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    sram_like_arbiter #(
        .OUTSTANDING (4), .STARVE_LIMIT (8), .ADDR_W (32), .DATA_W (32)
    ) dut (
        .clk (clk), .reset (reset),
        .inst_req (inst_req), .inst_wr (inst_wr), .inst_size (inst_size),
        .inst_wstrb (inst_wstrb), .inst_addr (inst_addr), .inst_wdata (inst_wdata),
        .inst_addr_ok (inst_addr_ok), .inst_data_ok (inst_data_ok), .inst_rdata (inst_rdata),
        .data_req (data_req), .data_wr (data_wr), .data_size (data_size),
        .data_wstrb (data_wstrb), .data_addr (data_addr), .data_wdata (data_wdata),
        .data_addr_ok (data_addr_ok), .data_data_ok (data_data_ok), .data_rdata (data_rdata),
        .m_req (m_req), .m_wr (m_wr), .m_size (m_size), .m_wstrb (m_wstrb),
        .m_addr (m_addr), .m_wdata (m_wdata), .m_addr_ok (m_addr_ok),
        .m_data_ok (m_data_ok), .m_rdata (m_rdata), .outstanding (outstanding)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_wstrb = 4'h0;
        inst_addr = '0; inst_wdata = '0;
        data_req = 0; data_wr = 0; data_size = SZ_WORD; data_wstrb = 4'h0;
        data_addr = '0; data_wdata = '0;
        m_addr_ok = 0; m_data_ok = 0; m_rdata = '0;
    endtask

    // Returns every queued response one per cycle, checking routing and data.
    task automatic test_drain(input string tag);
        int n;
        n = sb.size();
        for (int i = 0; i < n; i++) begin
            m_data_ok = 1; m_rdata = 32'hA5000000 + i;
            e = sb.pop_front();
            if (e.chk_rdata) m_rdata = e.rdata;
            #2;
            checks++;
            if ({inst_data_ok, data_data_ok} !== ((e.id == ID_INST) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL %s_resp%0d: {inst,data}_data_ok=%b expected id %0d", tag, i,
                         {inst_data_ok, data_data_ok}, e.id);
            end
            if (e.chk_rdata) begin
                checks++;
                if (((e.id == ID_INST) ? inst_rdata : data_rdata) !== e.rdata) begin
                    errors++;
                    $display("FAIL %s_rdata%0d: got %h expected %h", tag, i,
                             (e.id == ID_INST) ? inst_rdata : data_rdata, e.rdata);
                end
            end
            tick();
        end
        m_data_ok = 0;
        #2;
        checks++;
        if (outstanding !== 3'd0) begin
            errors++;
            $display("FAIL %s_drained: outstanding=%0d expected 0", tag, outstanding);
        end
        tick();
    endtask

    task automatic test_reset();
        idle();
        reset = 1; inst_req = 1; data_req = 1; m_addr_ok = 1; m_data_ok = 1;
        for (int i = 0; i < 2; i++) begin
            #2;
            checks++;
            if ({m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs: {m_req,addr_ok x2,data_ok x2}=%b expected 00000",
                         {m_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok});
            end
            tick();
        end
        reset = 0; idle();
        #2;
        checks++;
        if (outstanding !== 3'd0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: outstanding=%0d m_req=%b expected 0/0", outstanding, m_req);
        end
        tick();
    endtask

    task automatic test_single_inst();
        idle();
        inst_req = 1; inst_addr = 32'hBFC00000;
        #2;
        checks++;
        if (m_req !== 1'b1 || m_addr !== 32'hBFC00000 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL single_c0: m_req=%b m_addr=%h addr_ok=%b expected 1/bfc00000/0",
                     m_req, m_addr, inst_addr_ok);
        end
        tick();
        m_addr_ok = 1;
        #2;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || outstanding !== 3'd0) begin
            errors++;
            $display("FAIL single_accept: {inst,data}_addr_ok=%b outstanding=%0d expected 10/0",
                     {inst_addr_ok, data_addr_ok}, outstanding);
        end
        sb.push_back('{ID_INST, 32'h3C1D0001, 1'b1});
        tick();
        inst_req = 0; m_addr_ok = 0;
        #2;
        checks++;
        if (outstanding !== 3'd1 || {inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL single_wait: outstanding=%0d data_ok=%b expected 1/00",
                     outstanding, {inst_data_ok, data_data_ok});
        end
        tick();
        test_drain("single");
    endtask

    task automatic test_priority();
        idle();
        inst_req = 1; inst_addr = 32'hBFC00004;
        data_req = 1; data_wr = 1; data_wstrb = 4'hF;
        data_addr = 32'h80000010; data_wdata = 32'hDEADBEEF;
        m_addr_ok = 1;
        #2;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01 || m_addr !== 32'h80000010 ||
            m_wr !== 1'b1 || m_wstrb !== 4'hF || m_wdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL prio_data_first: addr_ok=%b m_addr=%h m_wr=%b m_wstrb=%h m_wdata=%h",
                     {inst_addr_ok, data_addr_ok}, m_addr, m_wr, m_wstrb, m_wdata);
        end
        sb.push_back('{ID_DATA, 32'h0, 1'b0});
        tick();
        data_req = 0;
        #2;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'hBFC00004 || m_wr !== 1'b0) begin
            errors++;
            $display("FAIL prio_inst_next: addr_ok=%b m_addr=%h m_wr=%b expected 10/bfc00004/0",
                     {inst_addr_ok, data_addr_ok}, m_addr, m_wr);
        end
        sb.push_back('{ID_INST, 32'h11112222, 1'b1});
        tick();
        idle();
        test_drain("prio");
    endtask

    task automatic test_lock();
        idle();
        inst_req = 1; inst_addr = 32'hBFC00100;
        for (int c = 0; c < 3; c++) begin
            if (c >= 1) begin
                data_req = 1; data_addr = 32'h80000020;
            end
            #2;
            checks++;
            if (m_req !== 1'b1 || m_addr !== 32'hBFC00100 || data_addr_ok !== 1'b0) begin
                errors++;
                $display("FAIL lock_hold%0d: m_req=%b m_addr=%h data_addr_ok=%b expected 1/bfc00100/0",
                         c, m_req, m_addr, data_addr_ok);
            end
            tick();
        end
        m_addr_ok = 1;
        #2;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b10 || m_addr !== 32'hBFC00100) begin
            errors++;
            $display("FAIL lock_accept: addr_ok=%b m_addr=%h expected 10/bfc00100",
                     {inst_addr_ok, data_addr_ok}, m_addr);
        end
        sb.push_back('{ID_INST, 32'h0BAD0001, 1'b1});
        tick();
        inst_req = 0;
        #2;
        checks++;
        if ({inst_addr_ok, data_addr_ok} !== 2'b01 || m_addr !== 32'h80000020) begin
            errors++;
            $display("FAIL lock_then_data: addr_ok=%b m_addr=%h expected 01/80000020",
                     {inst_addr_ok, data_addr_ok}, m_addr);
        end
        sb.push_back('{ID_DATA, 32'h0BAD0002, 1'b1});
        tick();
        idle();
        test_drain("lock");
    endtask

    task automatic test_full();
        idle();
        inst_req = 1; m_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            inst_addr = 32'hBFC00200 + 32'(4 * i);
            #2;
            checks++;
            if (inst_addr_ok !== 1'b1 || m_addr !== inst_addr) begin
                errors++;
                $display("FAIL full_accept%0d: addr_ok=%b m_addr=%h expected 1/%h",
                         i, inst_addr_ok, m_addr, inst_addr);
            end
            sb.push_back('{ID_INST, 32'h50000000 + 32'(i), 1'b1});
            tick();
        end
        inst_addr = 32'hBFC00210;
        #2;
        checks++;
        if (outstanding !== 3'd4 || m_req !== 1'b0 || inst_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL full_block: outstanding=%0d m_req=%b addr_ok=%b expected 4/0/0",
                     outstanding, m_req, inst_addr_ok);
        end
        e = sb.pop_front();
        m_data_ok = 1; m_rdata = e.rdata;
        #2;
        checks++;
        if (inst_data_ok !== 1'b1 || inst_rdata !== e.rdata || m_req !== 1'b0) begin
            errors++;
            $display("FAIL full_pop: data_ok=%b rdata=%h m_req=%b expected 1/%h/0",
                     inst_data_ok, inst_rdata, m_req, e.rdata);
        end
        tick();
        m_data_ok = 0;
        #2;
        checks++;
        if (outstanding !== 3'd3 || inst_addr_ok !== 1'b1) begin
            errors++;
            $display("FAIL full_resume: outstanding=%0d addr_ok=%b expected 3/1",
                     outstanding, inst_addr_ok);
        end
        sb.push_back('{ID_INST, 32'h50000004, 1'b1});
        tick();
        idle();
        test_drain("full");
    endtask

    task automatic test_starve();
        int      sc;
        int      inst_at;
        req_id_t exp_g;
        sc = 0; inst_at = -1;
        idle();
        inst_req = 1; inst_addr = 32'hBFC00300;
        data_req = 1; data_addr = 32'h80001000;
        m_addr_ok = 1; m_data_ok = 1; m_rdata = 32'h77770000;
        for (int k = 0; k < 12; k++) begin
            #2;
            exp_g = (sc == 8) ? ID_INST : ID_DATA;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({inst_data_ok, data_data_ok} !== ((e.id == ID_INST) ? 2'b10 : 2'b01)) begin
                    errors++;
                    $display("FAIL starve_resp%0d: data_ok=%b expected id %0d",
                             k, {inst_data_ok, data_data_ok}, e.id);
                end
            end
            checks++;
            if ({inst_addr_ok, data_addr_ok} !== ((exp_g == ID_INST) ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL starve_grant%0d: addr_ok=%b expected id %0d",
                         k, {inst_addr_ok, data_addr_ok}, exp_g);
            end
            if (inst_addr_ok === 1'b1 && inst_at < 0) inst_at = k;
            sb.push_back('{exp_g, 32'h0, 1'b0});
            sc = (exp_g == ID_INST) ? 0 : ((sc < 8) ? sc + 1 : 8);
            tick();
        end
        checks++;
        if (inst_at !== 8) begin
            errors++;
            $display("FAIL starve_inst_slot: first inst accept at %0d expected 8", inst_at);
        end
        idle();
        test_drain("starve");
    endtask

    task automatic test_reset_mid();
        idle();
        inst_req = 1; inst_addr = 32'hBFC00400; m_addr_ok = 1;
        tick();
        tick();
        inst_req = 0; data_req = 1; data_addr = 32'h80002000; m_addr_ok = 0;
        #2;
        checks++;
        if (outstanding !== 3'd2 || m_req !== 1'b1 || m_addr !== 32'h80002000) begin
            errors++;
            $display("FAIL rmid_setup: outstanding=%0d m_req=%b m_addr=%h expected 2/1/80002000",
                     outstanding, m_req, m_addr);
        end
        tick();
        reset = 1;
        #2;
        checks++;
        if (m_req !== 1'b0 || data_addr_ok !== 1'b0) begin
            errors++;
            $display("FAIL rmid_during: m_req=%b data_addr_ok=%b expected 0/0", m_req, data_addr_ok);
        end
        tick();
        reset = 0; idle();
        sb.delete();
        #2;
        checks++;
        if (outstanding !== 3'd0 || m_req !== 1'b0) begin
            errors++;
            $display("FAIL rmid_cleared: outstanding=%0d m_req=%b expected 0/0", outstanding, m_req);
        end
        tick();
        m_data_ok = 1; m_rdata = 32'hFFFF0000;
        #2;
        checks++;
        if ({inst_data_ok, data_data_ok} !== 2'b00) begin
            errors++;
            $display("FAIL rmid_stray: data_ok=%b expected 00", {inst_data_ok, data_data_ok});
        end
        tick();
        m_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC00500; m_addr_ok = 1;
        #2;
        checks++;
        if (m_req !== 1'b1 || inst_addr_ok !== 1'b1 || m_addr !== 32'hBFC00500) begin
            errors++;
            $display("FAIL rmid_unlocked: m_req=%b addr_ok=%b m_addr=%h expected 1/1/bfc00500",
                     m_req, inst_addr_ok, m_addr);
        end
        sb.push_back('{ID_INST, 32'h12345678, 1'b1});
        tick();
        idle();
        test_drain("rmid");
    endtask

    initial begin
        reset = 1;
        idle();
        tick();
        test_reset();
        test_single_inst();
        test_priority();
        test_lock();
        test_full();
        test_starve();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one downstream sram-like port (req/addr_ok/data_ok) between two upstream sram-like requesters: port 0 = inst, port 1 = data.
- Sits between the CPU top's inst/data sram interfaces and the single memory-side bridge.
- Provides fixed data-priority arbitration with a starvation guard for inst, address-phase grant locking, and an in-order outstanding-ID FIFO that routes each data_ok/rdata back to the requester that issued it.

Parameters:
OUTSTANDING, 4, max accepted-but-unanswered transactions; power of 2, at least 2
STARVE_LIMIT, 8, consecutive data grants while inst waits before inst is forced next
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
inst_req / data_req  in  1  upstream request
inst_wr / data_wr  in  1  write when 1
inst_size / data_size  in  2  0=byte 1=half 2=word
inst_wstrb / data_wstrb  in  4  byte strobes
inst_addr / data_addr  in  ADDR_W  address
inst_wdata / data_wdata  in  DATA_W  write data
inst_addr_ok / data_addr_ok  out  1  address accepted this cycle
inst_data_ok / data_data_ok  out  1  response returned this cycle
inst_rdata / data_rdata  out  DATA_W  read data (broadcast of m_rdata)
m_req  out  1  downstream request
m_wr, m_size, m_wstrb, m_addr, m_wdata  out  1/2/4/ADDR_W/DATA_W  muxed from granted requester
m_addr_ok  in  1  downstream accept
m_data_ok  in  1  downstream response (strictly in order)
m_rdata  in  DATA_W  downstream read data
outstanding  out  log2(OUTSTANDING)+1  current FIFO occupancy

Behaviour:
- Clock is clk; reset is synchronous, active-high. Reset clears lock, lock_id, FIFO pointers and count (outstanding=0), and starve_cnt=0. While reset=1, m_req and all *_addr_ok/*_data_ok are 0.
- Grant selection (combinational, when not locked):
  - If data_req=1 and not (inst_req=1 and starve_cnt==STARVE_LIMIT), grant data.
  - Otherwise, if inst_req=1, grant inst.
- Lock:
  - If m_req=1 and m_addr_ok=0 at a clock edge, set lock=1 and lock_id=grant.
  - While locked, grant=lock_id regardless of the other request.
  - Clear lock on m_addr_ok=1.
  - Upstream masters must hold req and payload until their addr_ok.
- Full gating: m_req = (granted requester's req) AND (count != OUTSTANDING). A full FIFO blocks acceptance even if m_data_ok pops in the same cycle.
- Accept: on m_req & m_addr_ok, push the grant id onto the FIFO. addr_ok is driven only to the granted requester, same cycle as m_addr_ok, zero latency.
- Response:
  - On m_data_ok with FIFO non-empty, pop the head; assert inst_data_ok or data_data_ok per head id, same cycle.
  - Simultaneous push and pop leaves count unchanged.
  - m_data_ok with FIFO empty is ignored; no upstream data_ok is asserted.
- Write responses use the same path; rdata is don't-care.
- Pointers wrap modulo OUTSTANDING.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each accepted data transaction while inst_req=1.
  - Resets to 0 on an accepted inst transaction, or when inst_req=0.
- Payload mux is driven by the current grant. Outputs are stable while locked.
- Latency through the arbiter is zero cycles in both phases; it is purely sequencing plus bookkeeping.

Decomposition:
- Shared package holds: requester ID constants (ID_INST=0, ID_DATA=1) and size encodings (SZ_BYTE/SZ_HALF/SZ_WORD).
- One natural sub-module: arb_id_fifo, a 1-bit-wide, OUTSTANDING-deep sync FIFO with push/pop/count/head outputs, reused for the response-order queue.

Test Plan:
- Single inst read, addr 0xBFC00000, m_addr_ok on cycle 1, m_data_ok with rdata 0x3C1D0001 on cycle 3 -> inst_addr_ok on cycle 1, inst_data_ok on cycle 3 with inst_rdata=0x3C1D0001, data_data_ok stays 0, outstanding 0→1→0.
- inst_req and data_req raised together (data write 0x8000_0010, wstrb 0xF) -> data granted first; inst granted the cycle after data_addr_ok; responses return data then inst in order.
- inst granted while m_addr_ok held low 3 cycles, data_req rising on cycle 1 -> lock holds grant on inst; m_addr stays inst_addr until m_addr_ok; then data granted.
- Downstream never returns data_ok; 5 back-to-back inst requests -> 4 accepted, outstanding=4, m_req=0 on the 5th. One m_data_ok -> outstanding=3 and the 5th is accepted the following cycle.
- data_req held high continuously with inst_req high -> exactly 8 data accepts, then 1 inst accept, then starve_cnt=0 and data resumes.
- Reset asserted with 2 outstanding and lock set -> next cycle outstanding=0, lock clear, m_req=0; a stray m_data_ok after reset produces no upstream data_ok.
